// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants for the programmable clock dividers.
// Half-period values (HP = half period in clk_25M cycles, minus one) for the
// common divided rates derived from the 25 MHz system clock, plus a helper
// that packs four channel half-periods into the DEF_HP parameter layout.
package clk_div_pkg;

  localparam int HP_W = 26;

  localparam logic [HP_W-1:0] HP_12M5  = 26'd0;
  localparam logic [HP_W-1:0] HP_100K  = 26'd124;
  localparam logic [HP_W-1:0] HP_10K   = 26'd1249;
  localparam logic [HP_W-1:0] HP_1K    = 26'd12499;
  localparam logic [HP_W-1:0] HP_200HZ = 26'd62499;
  localparam logic [HP_W-1:0] HP_100HZ = 26'd124999;
  localparam logic [HP_W-1:0] HP_2HZ   = 26'd6249999;
  localparam logic [HP_W-1:0] HP_1HZ   = 26'd12499999;

  // Channel 0 lands in the least significant slice, matching [i*CW +: CW].
  function automatic logic [4*HP_W-1:0] pack_def_hp(
    input logic [HP_W-1:0] hp3,
    input logic [HP_W-1:0] hp2,
    input logic [HP_W-1:0] hp1,
    input logic [HP_W-1:0] hp0
  );
    return {hp3, hp2, hp1, hp0};
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel.
// Ports:
//   clk_25M  system clock
//   reset    asynchronous active-low reset
//   en       registered channel enable
//   resync   restart strobe, loads pending half-period and zeroes the phase
//   wr       write strobe addressed to this channel
//   wr_hp    new half-period value (HP)
//   clk_out  divided square wave
//   tick     one-cycle strobe on clk_out rising edge
//   pend     written half-period not yet in effect
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int              CW     = HP_W,
  parameter logic [CW-1:0]   DEF_HP = '0
) (
  input  logic          clk_25M,
  input  logic          reset,
  input  logic          en,
  input  logic          resync,
  input  logic          wr,
  input  logic [CW-1:0] wr_hp,
  output logic          clk_out,
  output logic          tick,
  output logic          pend
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] active_hp;
  logic [CW-1:0] pending_hp;
  logic          wrap;

  // >= rather than == lets a count left above a smaller HP recover at once.
  assign wrap = (cnt >= active_hp);

  // Counter, toggle and half-period registers. The active half-period only
  // changes when a full period ends (wrap while high), on disable or on
  // resync, so no half-cycle is ever shortened or stretched. A write landing
  // on the same edge as a period-end wrap stays pending for the next period.
  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      pend       <= 1'b0;
      active_hp  <= DEF_HP;
      pending_hp <= DEF_HP;
    end else if (resync) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pend    <= 1'b0;
      if (wr) begin
        active_hp  <= wr_hp;
        pending_hp <= wr_hp;
      end else begin
        active_hp  <= pending_hp;
      end
    end else begin
      if (!en) begin
        cnt       <= '0;
        clk_out   <= 1'b0;
        tick      <= 1'b0;
        active_hp <= pending_hp;
        pend      <= 1'b0;
      end else if (wrap) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
        if (clk_out) begin
          active_hp <= pending_hp;
          pend      <= 1'b0;
        end
      end else begin
        cnt  <= cnt + CW'(1);
        tick <= 1'b0;
      end
      if (wr) begin
        pending_hp <= wr_hp;
        pend       <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable clock divider / tick generator.
// Ports:
//   clk_25M  system clock, 25 MHz
//   reset    asynchronous active-low reset
//   wr_en    write strobe for a channel half-period
//   wr_ch    channel addressed by the write (ignored when >= NCH)
//   wr_hp    new half-period value minus one
//   en_wr    strobe loading en_val into the enable bits
//   en_val   per-channel enable value
//   resync   restart all channels phase-aligned
//   clk_out  divided square waves
//   tick     one-cycle strobe per clk_out rising edge
//   pend     per-channel written value not yet in effect
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int                  NCH    = 4,
  parameter int                  CW     = HP_W,
  parameter int                  CHW    = 2,
  parameter logic [NCH*CW-1:0]   DEF_HP = pack_def_hp(HP_1HZ, HP_1K, HP_10K, HP_100K),
  parameter logic [NCH-1:0]      DEF_EN = '1
) (
  input  logic           clk_25M,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [CW-1:0]  wr_hp,
  input  logic           en_wr,
  input  logic [NCH-1:0] en_val,
  input  logic           resync,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pend
);

  logic [NCH-1:0] en_q;

  // Enable bits; channels react to the registered value on the next edge.
  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      en_q <= DEF_EN;
    end else if (en_wr) begin
      en_q <= en_val;
    end
  end

  // One channel per output bit. A wr_ch at or above NCH matches no channel,
  // so such writes fall away without touching any state.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic wr_sel;

    assign wr_sel = wr_en && (wr_ch == CHW'(i));

    clk_div_chan #(
      .CW     (CW),
      .DEF_HP (DEF_HP[i*CW +: CW])
    ) u_chan (
      .clk_25M (clk_25M),
      .reset   (reset),
      .en      (en_q[i]),
      .resync  (resync),
      .wr      (wr_sel),
      .wr_hp   (wr_hp),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pend    (pend[i])
    );
  end

endmodule
